// File: rtl/serial_muldiv.sv
// serial_muldiv: iterative HI/LO multiply/divide unit (mult, multu, div, divu, mthi, mtlo).
// One shift-add (multiply) or restoring shift-subtract (divide) step per cycle.
module serial_muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned DW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic             is_div_q;
  logic             sign_a_q;
  logic             sign_b_q;
  logic [WIDTH-1:0] acc_hi_q;   // product upper half / partial remainder
  logic [WIDTH-1:0] acc_lo_q;   // multiplier -> product lower half / dividend -> quotient
  logic [WIDTH-1:0] opnd_q;     // multiplicand / divisor magnitude
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             busy_q;
  logic             done_q;

  logic             sign_a_d;
  logic             sign_b_d;
  logic [WIDTH-1:0] mag_a_d;
  logic [WIDTH-1:0] mag_b_d;
  logic [WIDTH:0]   mul_sum_d;
  logic [WIDTH:0]   rem_sh_d;
  logic [WIDTH:0]   diff_d;
  logic [DW-1:0]    prod_d;
  logic [WIDTH-1:0] quo_d;
  logic [WIDTH-1:0] rem_d;

  // Operand magnitudes, one iteration step, and final sign correction.
  always_comb begin
    sign_a_d  = op[0] & opA[WIDTH-1];
    sign_b_d  = op[0] & opB[WIDTH-1];
    mag_a_d   = sign_a_d ? (~opA + WIDTH'(1)) : opA;
    mag_b_d   = sign_b_d ? (~opB + WIDTH'(1)) : opB;

    mul_sum_d = {1'b0, acc_hi_q};
    if (acc_lo_q[0]) begin
      mul_sum_d = {1'b0, acc_hi_q} + {1'b0, opnd_q};
    end

    rem_sh_d  = {acc_hi_q, acc_lo_q[WIDTH-1]};
    diff_d    = rem_sh_d - {1'b0, opnd_q};

    prod_d    = {acc_hi_q, acc_lo_q};
    quo_d     = acc_lo_q;
    rem_d     = acc_hi_q;
    if (sign_a_q ^ sign_b_q) begin
      prod_d = ~prod_d + DW'(1);
      quo_d  = ~quo_d + WIDTH'(1);
    end
    if (sign_a_q) begin
      rem_d = ~rem_d + WIDTH'(1);
    end
  end

  // Control FSM, datapath registers and HI/LO.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            is_div_q <= op[1];
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            acc_hi_q <= '0;
            if (op[1]) begin
              acc_lo_q <= mag_a_d;
              opnd_q   <= mag_b_d;
            end else begin
              acc_lo_q <= mag_b_d;
              opnd_q   <= mag_a_d;
            end
            cnt_q   <= CW'(WIDTH);
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            if (hi_we) hi_q <= wdata;
            if (lo_we) lo_q <= wdata;
          end
        end
        RUN: begin
          if (is_div_q) begin
            acc_hi_q <= diff_d[WIDTH] ? rem_sh_d[WIDTH-1:0] : diff_d[WIDTH-1:0];
            acc_lo_q <= {acc_lo_q[WIDTH-2:0], ~diff_d[WIDTH]};
          end else begin
            {acc_hi_q, acc_lo_q} <= {mul_sum_d, acc_lo_q[WIDTH-1:1]};
          end
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          if (is_div_q) begin
            hi_q <= rem_d;
            lo_q <= quo_d;
          end else begin
            hi_q <= prod_d[DW-1:WIDTH];
            lo_q <= prod_d[WIDTH-1:0];
          end
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: doc/serial_muldiv.md
# serial_muldiv

Iterative multiply/divide unit holding the HI/LO result registers for MIPS mult, multu, div, divu, mthi and mtlo. It sits downstream of the execute-stage stall logic: its `busy` output drives the `devwait` input of the multi-cycle stall circuit. The pipeline stalls on the request cycle and then keeps stalling for as long as `busy` is high. It uses one shift-add or shift-subtract iteration per cycle to keep area small.

## Interface
- WIDTH, 32, operand and HI/LO width; must be ≥ 4.
- clk  in  1  clock; all state changes on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  request a new operation; sampled only in IDLE.
- op  in  2  operation: 00 multu, 01 mult, 10 divu, 11 div.
- opA  in  WIDTH  multiplicand or dividend (rs).
- opB  in  WIDTH  multiplier or divisor (rt).
- hi_we  in  1  mthi: write wdata to HI.
- lo_we  in  1  mtlo: write wdata to LO.
- wdata  in  WIDTH  data for mthi and mtlo.
- hi  out  WIDTH  HI register (product upper half, or remainder).
- lo  out  WIDTH  LO register (product lower half, or quotient).
- busy  out  1  operation in progress; connects to devwait.
- done  out  1  one-cycle pulse when hi and lo take a new result.

## Operation
- Reset values: hi=0, lo=0, busy=0, done=0, state=IDLE, iteration counter=0, internal accumulators=0.
- The FSM has three states: IDLE, RUN and FIX.
- IDLE:
  - If start=1, latch op, the sign flags and the operand magnitudes. Signed ops (op[0]=1) take two's-complement absolute values; unsigned ops take operands as-is.
  - Also clear the 2·WIDTH-bit accumulator, load counter=WIDTH, and go to RUN.
- RUN, multiply:
  - If the multiplier LSB is 1, add the multiplicand to the accumulator upper half (WIDTH+1-bit sum).
  - Shift the {carry, accumulator, multiplier} chain right by 1.
- RUN, divide (restoring):
  - Shift the {remainder, dividend} chain left by 1.
  - Trial-subtract the divisor from the remainder (WIDTH+1-bit).
  - If the result is non-negative, keep it and set the quotient bit to 1; otherwise restore and set it to 0.
- RUN bookkeeping: the counter decrements every cycle. When the counter is 1 at a clock edge, that edge completes the last iteration and moves to FIX.
- FIX:
  - For signed ops, apply sign correction: negate the product if signA^signB; negate the quotient if signA^signB; negate the remainder if signA.
  - Write hi/lo (multiply: product[2W-1:W] and product[W-1:0]; divide: remainder and quotient).
  - Pulse done, go to IDLE.
- hi/lo change only in FIX or on mthi/mtlo. Otherwise they hold.
- mthi/mtlo:
  - Honoured only in IDLE with start=0; hi_we and lo_we may both be set in the same cycle.
  - Ignored in RUN or FIX, and ignored when start=1 in the same cycle (start wins).
- start in RUN or FIX is ignored and not queued. Upstream re-presents it after busy falls.
- Divide by zero (deterministic, no exception):
  - divu gives lo=all ones, hi=opA.
  - div gives hi=opA, and lo=1 if opA is negative, else all ones.
- div of the most-negative value by -1 gives lo=2^(W-1) (wraps) and hi=0.
- Reset asserted mid-operation aborts immediately and restores all reset values. No partial result is written.

## Timing
- Let E0 be the edge that samples start in IDLE.
- RUN occupies edges E1..E_WIDTH. FIX is the edge E_(WIDTH+1).
- busy is decoded from registered state (state≠IDLE), so it is glitch-free. It is high for exactly WIDTH+1 cycles, from after E0 until E_(WIDTH+1).
- done is high for the single cycle after E_(WIDTH+1), and new hi/lo values are visible in that same cycle.
- Total latency from the start cycle to a valid result is WIDTH+2 cycles (34 for WIDTH=32).
- A back-to-back start is accepted no earlier than E_(WIDTH+2).
- mthi/mtlo take effect at the sampling edge and are visible the next cycle.
- No combinational path from inputs to busy, hi or lo.

## Test plan
- Reset and write:
  - Stimulus: reset, then mthi 0xDEADBEEF and mtlo 0x12345678 in the same cycle.
  - Required response: hi=0, lo=0 and busy=0 while in reset; afterwards hi=0xDEADBEEF and lo=0x12345678, with done never asserted.
- multu:
  - Stimulus: multu 0xFFFFFFFF × 0xFFFFFFFF.
  - Required response: busy high for exactly 33 cycles; then hi=0xFFFFFFFE, lo=0x00000001, with a single done pulse.
- mult (signed):
  - Stimulus: mult -7 × 3.
  - Required response: hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- div (signed):
  - Stimulus: div -7 / 2, then div 0x80000000 / -1.
  - Required response: lo=0xFFFFFFFD and hi=0xFFFFFFFF; then lo=0x80000000 and hi=0.
- Divide by zero:
  - Stimulus: divu 100 / 0.
  - Required response: lo=0xFFFFFFFF, hi=100.
- Collisions and abort:
  - Stimulus: start and mtlo during RUN.
  - Required response: both ignored, and the result matches the original operands.
  - Stimulus: resetn dropped at iteration 10.
  - Required response: busy=0, hi=lo=0 immediately; the next multu 6×7 returns lo=42 with 34-cycle latency.
